// File: rtl/intmatmul_seq_engine.sv
// Sequential matrix-vector multiply: one MAC per cycle over snapshotted operands,
// Start/Busy/Done handshake with synchronous Abort.
//   state | meaning
//   sIdle | waiting for Start; operands not yet captured
//   sMac  | one product per cycle, row r / column k
//   sDone | one-cycle Done pulse, all rows valid
module intmatmul_seq_engine #(
   parameter int pVectorSize = 4,
   parameter int pWordSize   = 4
) (
   input  logic                                       Clk,
   input  logic                                       Reset,
   input  logic                                       Start,
   input  logic                                       Abort,
   input  logic [pVectorSize*pWordSize-1:0]             vectorInput,
   input  logic [pVectorSize*pVectorSize*pWordSize-1:0] matrixInput,
   output logic                                       Busy,
   output logic                                       Done,
   output logic [pVectorSize*pWordSize-1:0]             cOutput
);

   localparam int CW = (pVectorSize > 1) ? $clog2(pVectorSize) : 1;
   localparam logic [CW-1:0] LAST = CW'(pVectorSize - 1);

   typedef enum logic [1:0] {sIdle, sMac, sDone} state_t;

   state_t state, stateNext;
   logic launch, macStep;

   logic [pVectorSize*pWordSize-1:0]             vecSh;
   logic [pVectorSize*pVectorSize*pWordSize-1:0] matSh;
   logic [CW-1:0]                                rowIdx, colIdx;
   logic [pWordSize-1:0]                         acc, mElem, vElem, prod, sum;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) state <= sIdle;
      else        state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      Busy      = 1'b0;
      Done      = 1'b0;
      launch    = 1'b0;
      macStep   = 1'b0;
      case (state)
         sIdle: begin
            // Abort wins over a simultaneous Start
            if (Start && !Abort) begin
               launch    = 1'b1;
               stateNext = sMac;
            end
         end
         sMac: begin
            Busy = 1'b1;
            if (Abort) begin
               stateNext = sIdle;
            end else begin
               macStep = 1'b1;
               if (colIdx == LAST && rowIdx == LAST) stateNext = sDone;
            end
         end
         sDone: begin
            Busy      = 1'b1;
            Done      = 1'b1;
            stateNext = sIdle;
         end
         default: stateNext = sIdle;
      endcase
   end

   assign mElem = matSh[(int'(rowIdx) * pVectorSize + int'(colIdx)) * pWordSize +: pWordSize];
   assign vElem = vecSh[int'(colIdx) * pWordSize +: pWordSize];
   assign prod  = mElem * vElem;
   assign sum   = acc + prod;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         vecSh   <= '0;
         matSh   <= '0;
         rowIdx  <= '0;
         colIdx  <= '0;
         acc     <= '0;
         cOutput <= '0;
      end else if (launch) begin
         vecSh  <= vectorInput;
         matSh  <= matrixInput;
         rowIdx <= '0;
         colIdx <= '0;
         acc    <= '0;
      end else if (macStep) begin
         if (colIdx == LAST) begin
            cOutput[int'(rowIdx) * pWordSize +: pWordSize] <= sum;
            acc    <= '0;
            colIdx <= '0;
            if (rowIdx != LAST) rowIdx <= rowIdx + 1'b1;
         end else begin
            acc    <= sum;
            colIdx <= colIdx + 1'b1;
         end
      end
   end

endmodule
